// File: rtl/dmem_arb_pkg.sv
// Shared types, access-size codes and alignment helper for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DM_ADDRESS_DEF = 9;
  localparam int DATA_W_DEF     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef logic port_id_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unknown size codes are treated as word accesses.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic mis;
    case (funct3)
      F3_B, F3_BU: mis = 1'b0;
      F3_H, F3_HU: mis = addr_lo[0];
      default:     mis = |addr_lo;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both request ports plus the datamemory-side signals of the arbiter.
interface dmem_arbiter_if #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) ();

  logic                  p0_valid;
  logic                  p0_ready;
  logic                  p0_we;
  logic [DM_ADDRESS-1:0] p0_addr;
  logic [DATA_W-1:0]     p0_wdata;
  logic [2:0]            p0_funct3;
  logic                  p0_rvalid;
  logic [DATA_W-1:0]     p0_rdata;
  logic                  p0_err;

  logic                  p1_valid;
  logic                  p1_ready;
  logic                  p1_we;
  logic [DM_ADDRESS-1:0] p1_addr;
  logic [DATA_W-1:0]     p1_wdata;
  logic [2:0]            p1_funct3;
  logic                  p1_rvalid;
  logic [DATA_W-1:0]     p1_rdata;
  logic                  p1_err;

  logic                  MemRead;
  logic                  MemWrite;
  logic [DM_ADDRESS-1:0] mem_a;
  logic [DATA_W-1:0]     mem_wd;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rd;
  logic                  busy;

  modport slave (
    input  p0_valid, p0_we, p0_addr, p0_wdata, p0_funct3,
    input  p1_valid, p1_we, p1_addr, p1_wdata, p1_funct3,
    input  mem_rd,
    output p0_ready, p0_rvalid, p0_rdata, p0_err,
    output p1_ready, p1_rvalid, p1_rdata, p1_err,
    output MemRead, MemWrite, mem_a, mem_wd, mem_funct3, busy
  );

  modport master (
    output p0_valid, p0_we, p0_addr, p0_wdata, p0_funct3,
    output p1_valid, p1_we, p1_addr, p1_wdata, p1_funct3,
    output mem_rd,
    input  p0_ready, p0_rvalid, p0_rdata, p0_err,
    input  p1_ready, p1_rvalid, p1_rdata, p1_err,
    input  MemRead, MemWrite, mem_a, mem_wd, mem_funct3, busy
  );

endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-way round-robin picker; only last_grant is stateful.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       en,
  output logic [1:0] grant
);

  port_id_t last_grant;

  // On a tie the port that did not win last time is picked.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  // Reset value 1 lets port 0 win the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (en && (|grant)) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the datamemory between two requesters: round-robin grant, IDLE/ISSUE/RESP sequencing.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int DATA_W     = DATA_W_DEF
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  state_t state;
  state_t next_state;

  logic [1:0]            grant;
  logic                  accept;
  logic                  sel_we;
  logic [DM_ADDRESS-1:0] sel_addr;
  logic [DATA_W-1:0]     sel_wdata;
  logic [2:0]            sel_funct3;
  logic                  sel_mis;

  logic                  we_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [2:0]            funct3_q;
  port_id_t              port_q;
  logic                  err_q;
  logic [DATA_W-1:0]     rdata_q;

  dmem_rr_arbiter u_rr (
    .clk   (clk),
    .reset (reset),
    .valid ({bus.p1_valid, bus.p0_valid}),
    .en    (accept),
    .grant (grant)
  );

  // Ready is gated by reset so every output reads 0 while reset is held.
  assign accept     = (state == IDLE) && !reset && (|grant);
  assign sel_we     = grant[1] ? bus.p1_we     : bus.p0_we;
  assign sel_addr   = grant[1] ? bus.p1_addr   : bus.p0_addr;
  assign sel_wdata  = grant[1] ? bus.p1_wdata  : bus.p0_wdata;
  assign sel_funct3 = grant[1] ? bus.p1_funct3 : bus.p0_funct3;
  assign sel_mis    = is_misaligned(sel_funct3, sel_addr[1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = sel_mis ? RESP : ISSUE;
        end
      end
      ISSUE:   next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Misaligned requests clear rdata_q at accept and go straight to RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= 3'b000;
      port_q   <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else if (accept) begin
      we_q     <= sel_we;
      addr_q   <= sel_addr;
      wdata_q  <= sel_wdata;
      funct3_q <= sel_funct3;
      port_q   <= grant[1];
      err_q    <= sel_mis;
      rdata_q  <= '0;
    end else if (state == ISSUE) begin
      rdata_q  <= we_q ? '0 : bus.mem_rd;
    end
  end

  assign bus.p0_ready   = accept && grant[0];
  assign bus.p1_ready   = accept && grant[1];

  assign bus.MemRead    = (state == ISSUE) && !we_q;
  assign bus.MemWrite   = (state == ISSUE) && we_q;
  assign bus.mem_a      = addr_q;
  assign bus.mem_wd     = wdata_q;
  assign bus.mem_funct3 = funct3_q;
  assign bus.busy       = (state != IDLE);

  assign bus.p0_rvalid  = (state == RESP) && (port_q == 1'b0);
  assign bus.p1_rvalid  = (state == RESP) && (port_q == 1'b1);
  assign bus.p0_rdata   = bus.p0_rvalid ? rdata_q : '0;
  assign bus.p1_rdata   = bus.p1_rvalid ? rdata_q : '0;
  assign bus.p0_err     = bus.p0_rvalid && err_q;
  assign bus.p1_err     = bus.p1_rvalid && err_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the datamemory block. It shares the single data memory between port 0 (core load/store unit) and port 1 (program loader/debug).
- Round-robin grant and a valid/ready request handshake.
- Each access is sequenced through a fixed 3-state FSM.
- Misaligned accesses are rejected with an error response and never reach memory.

Parameters:
DM_ADDRESS, 9, memory address width (byte address).
DATA_W, 32, data width.

Ports:
clk  in  1  system clock; memory writes on falling edge inside datamemory
reset  in  1  asynchronous, active-high reset
p0_valid / p1_valid  in  1  request valid per port
p0_ready / p1_ready  out  1  request accepted this cycle (valid&ready = handshake)
p0_we / p1_we  in  1  1=store, 0=load
p0_addr / p1_addr  in  DM_ADDRESS  byte address
p0_wdata / p1_wdata  in  DATA_W  store data
p0_funct3 / p1_funct3  in  3  RISC-V access size code
p0_rvalid / p1_rvalid  out  1  one-cycle response strobe
p0_rdata / p1_rdata  out  DATA_W  load data, valid with rvalid
p0_err / p1_err  out  1  misaligned-access flag, valid with rvalid
MemRead  out  1  to datamemory
MemWrite  out  1  to datamemory
mem_a  out  DM_ADDRESS  to datamemory a
mem_wd  out  DATA_W  to datamemory wd
mem_funct3  out  3  to datamemory Funct3
mem_rd  in  DATA_W  from datamemory rd
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async) values: state=IDLE, last_grant=1 (port 0 wins first tie), all outputs 0, latched request registers 0.
- FSM states and transitions:
  - IDLE -> ISSUE on accept (aligned request).
  - IDLE -> RESP on accept (misaligned request).
  - ISSUE -> RESP unconditionally.
  - RESP -> IDLE unconditionally.
- IDLE:
  - pX_ready is combinational: asserted only for the granted port, only in IDLE.
  - Grant: the single valid port; if both are valid, the port != last_grant.
  - On accept, latch we/addr/wdata/funct3/port id and update last_grant.
  - Requester holds valid and payload stable until ready.
- Alignment check on accept:
  - funct3 000/100 (byte): always aligned.
  - funct3 001/101 (half): addr[0] must be 0.
  - funct3 010 and all others (word): addr[1:0] must be 00.
  - Misaligned: skip ISSUE, set err flag.
- ISSUE (exactly one cycle):
  - Drive mem_a, mem_wd and mem_funct3 from the latched registers.
  - Assert MemRead=!we or MemWrite=we, never both.
  - Capture mem_rd into rdata_q at the rising edge ending ISSUE; loads only, stores capture 0.
- RESP (one cycle):
  - rvalid=1 only for the latched port; rdata=rdata_q, err=err_q.
  - Misaligned: rdata=0, err=1.
  - Stores: rdata=0, err=0.
- MemRead/MemWrite are 0 outside ISSUE. mem_a/mem_wd/mem_funct3 hold their last latched values.
- Latency: accept at edge N -> memory access during cycle N+1 -> rvalid high during cycle N+2.
- Throughput: one access per 3 cycles. A misaligned access takes 2 cycles.
- A new request is not accepted during RESP; the next accept occurs earliest in the cycle after RESP.
- Port requests arriving while busy wait; there is no queueing inside the block.
- Reset mid-operation: the in-flight access is dropped and no rvalid is issued. A store in ISSUE may or may not have been written; software must not rely on either.
- rdata/err outputs for the non-latched port stay 0.

Decomposition:
- Package dmem_arb_pkg:
  - state_t enum {IDLE, ISSUE, RESP}.
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - port_id_t (1 bit).
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module dmem_rr_arbiter: 2-way round-robin picker (valid[1:0], last_grant, en -> grant one-hot, updates last_grant on en). It is combinational apart from the last_grant flop.

Test Plan:
- Port0 SW addr=0x010 wdata=0xDEADBEEF, then LW addr=0x010 -> MemWrite=1 exactly one cycle; second response p0_rvalid at accept+2 with rdata=0xDEADBEEF, err=0.
- Both ports valid every cycle with LW from different addresses -> grants alternate 0,1,0,1, starting with port 0 after reset; no rvalid on the wrong port.
- Port1 LH addr=0x013 -> no MemRead/MemWrite pulse, p1_rvalid one cycle after accept, err=1, rdata=0. Port1 LB addr=0x013 -> normal access, err=0.
- Store byte 0x80 at 0x020 after SW 0 there, then LB -> rdata=0xFFFFFF80.
- Port0 held valid during busy=1 -> p0_ready stays 0 until the cycle after RESP; payload is latched only at the handshake.
- Assert reset during ISSUE of a load -> all outputs 0 immediately, no rvalid afterward; first post-reset request is accepted normally with port 0 priority.
